// File: rtl/pic_q_sequencer_pkg.sv
// Shared ALU op codes and the opcode decoder
// for the PIC16-style Q-phase sequencer.
package pic_q_sequencer_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_PASSL = 4'd0;
  localparam alu_op_t ALU_PASSW = 4'd1;
  localparam alu_op_t ALU_PASSF = 4'd2;
  localparam alu_op_t ALU_ADD   = 4'd3;
  localparam alu_op_t ALU_SUB   = 4'd4;
  localparam alu_op_t ALU_AND   = 4'd5;
  localparam alu_op_t ALU_IOR   = 4'd6;
  localparam alu_op_t ALU_XOR   = 4'd7;
  localparam alu_op_t ALU_INC   = 4'd8;
  localparam alu_op_t ALU_DEC   = 4'd9;
  localparam alu_op_t ALU_BTST  = 4'd10;

  typedef struct packed {
    logic    legal;
    logic    file_rd;
    logic    lit;
    logic    wb;
    logic    movwf;
    logic    status;
    logic    skip;
    logic    skip_inv;
    logic    jump;
    logic    call;
    logic    ret;
    alu_op_t op;
  } dec_t;

  function automatic dec_t decode(input logic [13:0] i);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    casez (i)
      14'b00_0000_0000_1000: d.ret = 1'b1;
      14'b00_0000_0??0_0000: d.op = ALU_PASSL;
      14'b00_0000_1???_????: begin
        d.movwf = 1'b1;
        d.op = ALU_PASSW;
      end
      14'b00_0111_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_ADD;
      end
      14'b00_0010_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_SUB;
      end
      14'b00_0101_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_AND;
      end
      14'b00_0100_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_IOR;
      end
      14'b00_0110_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_XOR;
      end
      14'b00_0011_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_DEC;
      end
      14'b00_1010_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_INC;
      end
      14'b00_1000_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.status = 1'b1; d.op = ALU_PASSF;
      end
      14'b00_1011_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.skip = 1'b1; d.op = ALU_DEC;
      end
      14'b00_1111_????_????: begin
        d.file_rd = 1'b1; d.wb = 1'b1;
        d.skip = 1'b1; d.op = ALU_INC;
      end
      14'b01_10??_????_????: begin
        d.file_rd = 1'b1; d.skip = 1'b1;
        d.skip_inv = 1'b1; d.op = ALU_BTST;
      end
      14'b01_11??_????_????: begin
        d.file_rd = 1'b1; d.skip = 1'b1;
        d.op = ALU_BTST;
      end
      14'b10_0???_????_????: begin
        d.jump = 1'b1; d.call = 1'b1;
      end
      14'b10_1???_????_????: d.jump = 1'b1;
      14'b11_00??_????_????: begin
        d.lit = 1'b1; d.op = ALU_PASSL;
      end
      14'b11_111?_????_????: begin
        d.lit = 1'b1; d.status = 1'b1;
        d.op = ALU_ADD;
      end
      14'b11_110?_????_????: begin
        d.lit = 1'b1; d.status = 1'b1;
        d.op = ALU_SUB;
      end
      14'b11_1001_????_????: begin
        d.lit = 1'b1; d.status = 1'b1;
        d.op = ALU_AND;
      end
      14'b11_1000_????_????: begin
        d.lit = 1'b1; d.status = 1'b1;
        d.op = ALU_IOR;
      end
      14'b11_1010_????_????: begin
        d.lit = 1'b1; d.status = 1'b1;
        d.op = ALU_XOR;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pic_q_sequencer_q_phase_counter.sv
// Modulo-Q phase counter with hold; flags
// the last phase of each instruction cycle.
module q_phase_counter #(
  parameter int Q  = 4,
  parameter int QW = $clog2(Q)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  output logic [QW-1:0] q_count,
  output logic          is_last
);

  assign is_last = (q_count == QW'(Q - 1));

  always_ff @(posedge clk) begin
    if (rst)
      q_count <= '0;
    else if (!hold)
      q_count <= is_last ? '0 : q_count + QW'(1);
  end

endmodule

// File: rtl/pic_q_sequencer.sv
// Q-phase sequencer: flush/skip state plus
// phase-qualified decode into datapath strobes.
module pic_q_sequencer
  import pic_q_sequencer_pkg::*;
#(
  parameter int Q_PER_CYCLE = 4,
  parameter int ALU_OP_W    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [13:0]                    instr_current,
  input  logic                           skip_cond,
  output logic [$clog2(Q_PER_CYCLE)-1:0] q_count,
  output logic                           in_flush,
  output logic                           alu_sel_l,
  output logic [ALU_OP_W-1:0]            alu_op,
  output logic                           alu_status_wr_en,
  output logic                           file_rd_en,
  output logic                           file_wr_en,
  output logic                           w_reg_wr_en,
  output logic                           instr_rd_en,
  output logic                           instr_flush,
  output logic                           pc_incr_en,
  output logic                           pc_j_en,
  output logic                           pc_ret_en,
  output logic                           stack_push,
  output logic                           illegal_instr
);

  localparam int QW = $clog2(Q_PER_CYCLE);
  localparam logic [QW-1:0] Q_RD = QW'(1);
  localparam logic [QW-1:0] Q_EX = QW'(2);

  logic is_last;
  logic skip_pending;
  logic act;
  logic dbit;
  dec_t d;

  q_phase_counter #(.Q(Q_PER_CYCLE)) u_qc (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .q_count (q_count),
    .is_last (is_last)
  );

  assign d    = decode(instr_current);
  assign dbit = instr_current[7];
  assign act  = !hold && !rst;

  // A redirect at the last phase turns the next cycle into a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flush     <= 1'b1;
      skip_pending <= 1'b0;
    end else if (!hold) begin
      if (is_last) begin
        skip_pending <= 1'b0;
        in_flush     <= !in_flush &&
                        (skip_pending || d.jump || d.ret);
      end else if (!in_flush && q_count == Q_EX && d.skip) begin
        skip_pending <= d.skip_inv ? !skip_cond : skip_cond;
      end
    end
  end

  always_comb begin
    alu_sel_l        = 1'b0;
    alu_op           = '0;
    alu_status_wr_en = 1'b0;
    file_rd_en       = 1'b0;
    file_wr_en       = 1'b0;
    w_reg_wr_en      = 1'b0;
    instr_rd_en      = 1'b0;
    instr_flush      = 1'b0;
    pc_incr_en       = 1'b0;
    pc_j_en          = 1'b0;
    pc_ret_en        = 1'b0;
    stack_push       = 1'b0;
    illegal_instr    = 1'b0;
    if (act && in_flush) begin
      instr_rd_en = is_last;
      pc_incr_en  = is_last;
    end else if (act) begin
      if (q_count == Q_RD)
        file_rd_en = d.file_rd;
      if (q_count == Q_EX) begin
        alu_op           = ALU_OP_W'(d.op);
        alu_sel_l        = d.lit;
        alu_status_wr_en = d.status;
        w_reg_wr_en      = d.lit || (d.wb && !dbit);
        file_wr_en       = d.movwf || (d.wb && dbit);
      end
      if (is_last) begin
        illegal_instr = !d.legal;
        if (skip_pending) begin
          pc_incr_en  = 1'b1;
          instr_flush = 1'b1;
        end else if (d.jump) begin
          pc_j_en     = 1'b1;
          stack_push  = d.call;
          instr_flush = 1'b1;
        end else if (d.ret) begin
          pc_ret_en   = 1'b1;
          instr_flush = 1'b1;
        end else begin
          instr_rd_en = 1'b1;
          pc_incr_en  = 1'b1;
        end
      end
    end
  end

endmodule
